// File: rtl/alu_pkg.sv
// Shared encodings for the integer ALU path and the FP ALU decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // in_op encoding. SUB is A + ~B + 1, so op[0] doubles as the initial carry-in.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between an op issuer and the bit-serial ALU.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the result side.
// Signals: in_valid/in_ready/in_a/in_b/in_op (request), out_valid/out_ready/
//          out_result/out_z/out_n/out_c/out_v (result), busy (status).
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_z;
    logic             out_n;
    logic             out_c;
    logic             out_v;
    logic             busy;

    // master: the issuer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_z, out_n, out_c, out_v, busy
    );

    // slave: the ALU controller side
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_z, out_n, out_c, out_v, busy
    );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: sum/carry for ADD/SUB, bitwise AND/OR.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, cin, op in; r (result bit), cout (carry out, 0 for AND/OR) out.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    r,
    output logic    cout
);

    logic bb;

    // SUB adds the inverted subtrahend; the +1 comes in through the first cin.
    assign bb = (op == ALU_SUB) ? ~b : b;

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                r    = a ^ bb ^ cin;
                cout = (a & bb) | (a & cin) | (bb & cin);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one op at a time, LSB-first through a 1-bit slice.
// Latency: out_valid WIDTH cycles after accept (AND/OR: 1 cycle when ALU_SERIAL_LOGIC_FAST_EN).
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
// Ports: clk, rst (sync, active high), bus (alu_serial_ctrl_if.slave).
// Build option: ALU_SERIAL_LOGIC_FAST_EN resolves AND/OR in parallel on accept.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_serial_ctrl_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    alu_state_e       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_op_e          op_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             zacc;
    logic [WIDTH-2:0] sh;       // low result bits collected so far, top-aligned
    logic [WIDTH-1:0] res_q;
    logic             z_q, n_q, c_q, v_q;
    logic             ov_q;
    logic             ir_q;
    logic             busy_q;

    logic             bit_r;
    logic             bit_c;
    logic [WIDTH-1:0] sh_full;
    logic             is_logic;

    alu_bit_slice u_slice (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .cin  (carry),
        .op   (op_q),
        .r    (bit_r),
        .cout (bit_c)
    );

    // New bit enters at the top; after WIDTH steps bit 0 has reached position 0.
    assign sh_full  = {bit_r, sh};
    assign is_logic = (op_q == ALU_AND) || (op_q == ALU_OR);

`ifdef ALU_SERIAL_LOGIC_FAST_EN
    logic [WIDTH-1:0] fast_res;
    assign fast_res = bus.in_op[0] ? (bus.in_a | bus.in_b) : (bus.in_a & bus.in_b);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= ALU_ADD;
            cnt    <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b0;
            sh     <= '0;
            res_q  <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            ov_q   <= 1'b0;
            ir_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.in_a;
                        b_q    <= bus.in_b;
                        op_q   <= alu_op_e'(bus.in_op);
                        cnt    <= '0;
                        carry  <= bus.in_op[0];
                        zacc   <= 1'b0;
                        ir_q   <= 1'b0;
                        busy_q <= 1'b1;
`ifdef ALU_SERIAL_LOGIC_FAST_EN
                        if (bus.in_op[1]) begin
                            // Result lands now; out_valid follows on the next edge in DONE.
                            res_q <= fast_res;
                            z_q   <= (fast_res == '0);
                            n_q   <= fast_res[WIDTH-1];
                            c_q   <= 1'b0;
                            v_q   <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
`else
                        state  <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    sh    <= sh_full[WIDTH-1:1];
                    carry <= bit_c;
                    zacc  <= zacc | bit_r;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        res_q <= sh_full;
                        z_q   <= ~(zacc | bit_r);
                        n_q   <= bit_r;
                        c_q   <= is_logic ? 1'b0 : bit_c;
                        // carry is the MSB's carry-in at this point
                        v_q   <= is_logic ? 1'b0 : (carry ^ bit_c);
                        ov_q  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!ov_q) begin
                        ov_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        ov_q   <= 1'b0;
                        ir_q   <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ov_q   <= 1'b0;
                    ir_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = ir_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_result = res_q;
    assign bus.out_z      = z_q;
    assign bus.out_n      = n_q;
    assign bus.out_c      = c_q;
    assign bus.out_v      = v_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=32.
// Latency: checks WIDTH-cycle serial latency and the logic-op latency of the build.
// Backpressure: holds out_ready low in DONE and checks result stability and no overlap.
module tb_alu_serial_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   lat;

`ifdef ALU_SERIAL_LOGIC_FAST_EN
    localparam int LOGIC_LAT = 1;
`else
    localparam int LOGIC_LAT = 32;
`endif

    alu_serial_ctrl_if #(.WIDTH(32)) bus ();

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an op while IDLE, let it be accepted, then scramble the inputs.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_op    = op ^ 2'b01;
    endtask

    // Count edges after accept until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic [3:0] zncv);
        chk({tag, "_res"}, 64'(bus.out_result), 64'(res));
        chk({tag, "_zncv"}, 64'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 64'(zncv));
    endtask

    task automatic handshake(input string tag, input logic [31:0] res);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ovld_after"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rdy_after"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_res_hold"}, 64'(bus.out_result), 64'(res));
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        chk("rst_ovld", 64'(bus.out_valid), 64'd0);
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk_out("rst", 32'h0, 4'b0000);

        // 1: ADD signed overflow
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_rdy_run", 64'(bus.in_ready), 64'd0);
        wait_done(lat);
        chk("t1_lat", 64'(lat), 64'd32);
        chk_out("t1", 32'h8000_0000, 4'b0101);
        handshake("t1", 32'h8000_0000);

        // 2: SUB equal operands
        start_op(32'd5, 32'd5, 2'b01);
        wait_done(lat);
        chk("t2_lat", 64'(lat), 64'd32);
        chk_out("t2", 32'h0, 4'b1010);
        handshake("t2", 32'h0);

        // 3: SUB with borrow
        start_op(32'd0, 32'd1, 2'b01);
        wait_done(lat);
        chk_out("t3", 32'hFFFF_FFFF, 4'b0100);
        handshake("t3", 32'hFFFF_FFFF);

        // ADD wrap to zero
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        wait_done(lat);
        chk_out("wrap", 32'h0, 4'b1010);
        handshake("wrap", 32'h0);

        // OR, serial or fast depending on build
        start_op(32'h0F0F_0000, 32'h0000_00F0, 2'b11);
        wait_done(lat);
        chk("or_lat", 64'(lat), 64'(LOGIC_LAT));
        chk_out("or", 32'h0F0F_00F0, 4'b0000);
        handshake("or", 32'h0F0F_00F0);

        // 4: AND
        start_op(32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10);
        wait_done(lat);
        chk("t4_lat", 64'(lat), 64'(LOGIC_LAT));
        chk_out("t4", 32'hF000_F000, 4'b0100);

        // 5: hold in DONE with a competing request pending
        bus.in_a     = 32'h1234_5678;
        bus.in_b     = 32'h1111_1111;
        bus.in_op    = 2'b00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t5_ovld", 64'(bus.out_valid), 64'd1);
            chk("t5_rdy", 64'(bus.in_ready), 64'd0);
        end
        chk_out("t5", 32'hF000_F000, 4'b0100);
        handshake("t5", 32'hF000_F000);
        chk("t5_busy_hs", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("t5_accept_busy", 64'(bus.busy), 64'd1);
        chk("t5_accept_rdy", 64'(bus.in_ready), 64'd0);

        // 6: reset at RUN bit 10
        repeat (10) @(posedge clk);
        #1;
        chk("t6_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_ovld", 64'(bus.out_valid), 64'd0);
        chk("t6_rdy", 64'(bus.in_ready), 64'd1);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk_out("t6_rst", 32'h0, 4'b0000);
        start_op(32'd3, 32'd4, 2'b00);
        wait_done(lat);
        chk("t6_lat", 64'(lat), 64'd32);
        chk_out("t6", 32'd7, 4'b0000);
        handshake("t6", 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
